// File: rtl/decode_pipe_stage.sv
// Decode-to-execute pipeline register with load-use hazard stall, flush and a bubble counter.
// Defining DECODE_PIPE_SKID_EN adds a one-entry skid buffer so in_ready does not depend on out_ready.
module decode_pipe_stage #(
  parameter int XLEN      = 32,
  parameter int CTRL_W    = 13,
  parameter int NFLUSH    = 2,
  parameter int MEMRD_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [XLEN-1:0]   instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [NFLUSH-1:0] flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   instr_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [2:0]        funct3_e,
  output logic              hazard_stall,
  output logic [15:0]       bubble_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              flush_any, accept, handshake;
  logic              nxt_valid;
  logic [CTRL_W-1:0] nxt_ctrl;
  logic [XLEN-1:0]   nxt_instr, nxt_pc, nxt_pcplus4, nxt_rd1, nxt_rd2, nxt_imm;

  // Register-index fields come from the held instruction, so clearing instr_e clears them too.
  assign rs1_e    = instr_e[19:15];
  assign rs2_e    = instr_e[24:20];
  assign rd_e     = instr_e[11:7];
  assign funct3_e = instr_e[14:12];

  assign flush_any    = |flush;
  assign handshake    = out_valid & out_ready;
  assign hazard_stall = out_valid & ctrl_e[MEMRD_BIT] & (rd_e != 5'd0) &
                        ((rd_e == instr_d[19:15]) | (rd_e == instr_d[24:20]));
  assign accept       = in_valid & in_ready;

`ifdef DECODE_PIPE_SKID_EN
  logic              main_take;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [XLEN-1:0]   skid_instr, skid_pc, skid_pcplus4, skid_rd1, skid_rd2, skid_imm;

  assign main_take = ~out_valid | out_ready;
  assign in_ready  = ~skid_valid & ~hazard_stall;

  // Skid stage: catches an entry accepted while main is held, drains on the next handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid   <= 1'b0;
      skid_ctrl    <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_pcplus4 <= '0;
      skid_rd1     <= '0;
      skid_rd2     <= '0;
      skid_imm     <= '0;
    end else if (flush_any) begin
      skid_valid <= 1'b0;
    end else if (main_take && skid_valid) begin
      skid_valid <= 1'b0;
    end else if (accept && !main_take) begin
      skid_valid   <= 1'b1;
      skid_ctrl    <= ctrl_d;
      skid_instr   <= instr_d;
      skid_pc      <= pc_d;
      skid_pcplus4 <= pcplus4_d;
      skid_rd1     <= rd1_d;
      skid_rd2     <= rd2_d;
      skid_imm     <= imm_d;
    end
  end
`else
  assign in_ready = (~out_valid | out_ready) & ~hazard_stall;
`endif

  always_comb begin
    nxt_valid   = out_valid;
    nxt_ctrl    = ctrl_e;
    nxt_instr   = instr_e;
    nxt_pc      = pc_e;
    nxt_pcplus4 = pcplus4_e;
    nxt_rd1     = rd1_e;
    nxt_rd2     = rd2_e;
    nxt_imm     = imm_e;
    if (flush_any) begin
      // pc/pcplus4 survive a flush; everything else is zeroed
      nxt_valid = 1'b0;
      nxt_ctrl  = '0;
      nxt_instr = '0;
      nxt_rd1   = '0;
      nxt_rd2   = '0;
      nxt_imm   = '0;
`ifdef DECODE_PIPE_SKID_EN
    end else if (main_take && skid_valid) begin
      nxt_valid   = 1'b1;
      nxt_ctrl    = skid_ctrl;
      nxt_instr   = skid_instr;
      nxt_pc      = skid_pc;
      nxt_pcplus4 = skid_pcplus4;
      nxt_rd1     = skid_rd1;
      nxt_rd2     = skid_rd2;
      nxt_imm     = skid_imm;
    end else if (main_take && accept) begin
`else
    end else if (accept) begin
`endif
      nxt_valid   = 1'b1;
      nxt_ctrl    = ctrl_d;
      nxt_instr   = instr_d;
      nxt_pc      = pc_d;
      nxt_pcplus4 = pcplus4_d;
      nxt_rd1     = rd1_d;
      nxt_rd2     = rd2_d;
      nxt_imm     = imm_d;
    end else if (handshake) begin
      // Consumed with nothing behind it (including a load-use stall): emit a bubble.
      nxt_valid = 1'b0;
      nxt_ctrl  = '0;
      nxt_instr = '0;
    end
  end

  // Main stage register feeding execute
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ctrl_e    <= '0;
      instr_e   <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_e     <= '0;
    end else begin
      out_valid <= nxt_valid;
      ctrl_e    <= nxt_ctrl;
      instr_e   <= nxt_instr;
      pc_e      <= nxt_pc;
      pcplus4_e <= nxt_pcplus4;
      rd1_e     <= nxt_rd1;
      rd2_e     <= nxt_rd2;
      imm_e     <= nxt_imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= 16'd0;
    end else if (hazard_stall && in_valid) begin
      bubble_cnt <= sat_inc16(bubble_cnt);
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Randomized self-checking bench for decode_pipe_stage against a queue-based model of the stage.
module tb_decode_pipe_stage;
  localparam int XLEN = 32, CTRL_W = 13, NFLUSH = 2;
`ifdef DECODE_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0, rst = 1'b0;
  logic              in_valid, in_ready, out_valid, out_ready, hazard_stall;
  logic [CTRL_W-1:0] ctrl_d, ctrl_e;
  logic [XLEN-1:0]   instr_d, pc_d, pcplus4_d, rd1_d, rd2_d, imm_d;
  logic [XLEN-1:0]   instr_e, pc_e, pcplus4_e, rd1_e, rd2_e, imm_e;
  logic [NFLUSH-1:0] flush;
  logic [4:0]        rs1_e, rs2_e, rd_e;
  logic [2:0]        funct3_e;
  logic [15:0]       bubble_cnt;

  decode_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_d(ctrl_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_e(ctrl_e), .instr_e(instr_e),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .funct3_e(funct3_e),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   instr, pc, pcp4, rd1, rd2, imm;
  } ent_t;

  ent_t q[$];
  int   checks = 0, errors = 0, exp_cnt = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent(input bit allow_load);
    ent_t e;
    e.ctrl  = CTRL_W'($urandom);
    if (!allow_load) e.ctrl[1] = 1'b0;
    e.instr = $urandom;
    e.instr[19:15] = 5'($urandom_range(0, 3));
    e.instr[24:20] = 5'($urandom_range(0, 3));
    e.instr[11:7]  = 5'($urandom_range(0, 3));
    e.pc = $urandom; e.pcp4 = $urandom; e.rd1 = $urandom; e.rd2 = $urandom; e.imm = $urandom;
    return e;
  endfunction

  function automatic ent_t mk(input bit load, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ent_t e;
    e = rand_ent(1'b0);
    e.ctrl[1] = load;
    e.instr[11:7] = rd; e.instr[19:15] = rs1; e.instr[24:20] = rs2;
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic [1:0] fl);
    in_valid = v; ctrl_d = e.ctrl; instr_d = e.instr; pc_d = e.pc; pcplus4_d = e.pcp4;
    rd1_d = e.rd1; rd2_d = e.rd2; imm_d = e.imm; out_ready = ordy; flush = fl;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic step();
    bit          haz, rdy, pcchk;
    logic [4:0]  hrd;
    logic [31:0] fpc, fpc4;
    ent_t        e, h;
    #1;
    haz = 1'b0;
    if (q.size() > 0) begin
      hrd = q[0].instr[11:7];
      haz = q[0].ctrl[1] && hrd != 5'd0 && (hrd == instr_d[19:15] || hrd == instr_d[24:20]);
    end
`ifdef DECODE_PIPE_SKID_EN
    rdy = (q.size() < CAP) && !haz;
`else
    rdy = (q.size() == 0 || out_ready) && !haz;
`endif
    chk("hazard_stall", 64'(hazard_stall), 64'(haz));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (haz && in_valid && exp_cnt < 65535) exp_cnt++;
    pcchk = 1'b0;
    last_acc = 1'b0;
    e = '{ctrl_d, instr_d, pc_d, pcplus4_d, rd1_d, rd2_d, imm_d};
    if (|flush) begin
      if (q.size() > 0) begin pcchk = 1'b1; fpc = q[0].pc; fpc4 = q[0].pcp4; end
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin q.push_back(e); last_acc = 1'b1; end
    end
    @(posedge clk); #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      chk("ctrl_e", 64'(ctrl_e), 64'(h.ctrl));
      chk("instr_e", 64'(instr_e), 64'(h.instr));
      chk("pc_e", 64'(pc_e), 64'(h.pc));
      chk("pcplus4_e", 64'(pcplus4_e), 64'(h.pcp4));
      chk("rd1_e", 64'(rd1_e), 64'(h.rd1));
      chk("rd2_e", 64'(rd2_e), 64'(h.rd2));
      chk("imm_e", 64'(imm_e), 64'(h.imm));
      chk("rs1_e", 64'(rs1_e), 64'(h.instr[19:15]));
      chk("rs2_e", 64'(rs2_e), 64'(h.instr[24:20]));
      chk("rd_e", 64'(rd_e), 64'(h.instr[11:7]));
      chk("funct3_e", 64'(funct3_e), 64'(h.instr[14:12]));
    end else begin
      chk("idle_ctrl_e", 64'(ctrl_e), 64'd0);
      chk("idle_instr_e", 64'(instr_e), 64'd0);
      chk("idle_rd_e", 64'(rd_e), 64'd0);
    end
    if (pcchk) begin
      chk("flush_pc_e", 64'(pc_e), 64'(fpc));
      chk("flush_pcplus4_e", 64'(pcplus4_e), 64'(fpc4));
      chk("flush_rd1_e", 64'(rd1_e), 64'd0);
      chk("flush_imm_e", 64'(imm_e), 64'd0);
    end
    chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_cnt));
  endtask

  initial begin
    ent_t idle, d, l;
    int   sent;
    idle = '0;
    drive(1'b0, idle, 1'b0, 2'b00);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl_e", 64'(ctrl_e), 64'd0);
    chk("rst_pc_e", 64'(pc_e), 64'd0);
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // stream of 10 back-to-back entries, first accept on the first edge after reset
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_ent(1'b0), 1'b1, 2'b00);
      step();
    end
    drive(1'b0, idle, 1'b1, 2'b00);
    step();
    chk("stream_bubble_cnt", 64'(bubble_cnt), 64'd0);

    // load-use: main holds a load to x5, decode reads x5
    l = mk(1'b1, 5'd5, 5'd0, 5'd0);
    d = mk(1'b0, 5'd1, 5'd5, 5'd0);
    drive(1'b1, l, 1'b0, 2'b00); step();
    drive(1'b1, d, 1'b1, 2'b00); step();
    step(); step();
    drive(1'b0, idle, 1'b1, 2'b00); step();
    chk("loaduse_bubble_cnt", 64'(bubble_cnt), 64'd1);

    // same with rd=x0: no stall
    l = mk(1'b1, 5'd0, 5'd0, 5'd0);
    d = mk(1'b0, 5'd1, 5'd0, 5'd0);
    drive(1'b1, l, 1'b0, 2'b00); step();
    drive(1'b1, d, 1'b1, 2'b00); step();
    drive(1'b0, idle, 1'b1, 2'b00); step(); step();
    chk("x0_bubble_cnt", 64'(bubble_cnt), 64'd1);

    // backpressure: 2 entries offered while out_ready=0 for 3 cycles, then drain
    sent = 0;
    d = rand_ent(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(sent < 2, d, 1'b0, 2'b00); step();
      if (last_acc) begin sent++; d = rand_ent(1'b0); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(sent < 2, d, 1'b1, 2'b00); step();
      if (last_acc) begin sent++; d = rand_ent(1'b0); end
    end

    // flush with main (and skid) full while a new entry is offered
    drive(1'b1, rand_ent(1'b0), 1'b0, 2'b00); step();
    drive(1'b1, rand_ent(1'b0), 1'b0, 2'b00); step();
    drive(1'b1, rand_ent(1'b0), 1'b0, 2'b10); step();
    drive(1'b0, idle, 1'b1, 2'b00); step();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_ent(1'b1), $urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      step();
    end
    drive(1'b0, idle, 1'b1, 2'b00); step(); step();

    // saturation: hold a load-use stall for 65540 cycles
    l = mk(1'b1, 5'd5, 5'd0, 5'd0);
    d = mk(1'b0, 5'd1, 5'd5, 5'd0);
    drive(1'b1, l, 1'b0, 2'b00); step();
    drive(1'b1, d, 1'b0, 2'b00);
    repeat (65540) @(posedge clk);
    #1;
    exp_cnt = 65535;
    chk("sat_bubble_cnt", 64'(bubble_cnt), 64'hFFFF);
    chk("sat_hazard_stall", 64'(hazard_stall), 64'd1);

    // asynchronous reset mid-transfer
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    exp_cnt = 0;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_ctrl_e", 64'(ctrl_e), 64'd0);
    chk("arst_instr_e", 64'(instr_e), 64'd0);
    chk("arst_pc_e", 64'(pc_e), 64'd0);
    chk("arst_pcplus4_e", 64'(pcplus4_e), 64'd0);
    chk("arst_rd1_e", 64'(rd1_e), 64'd0);
    chk("arst_imm_e", 64'(imm_e), 64'd0);
    chk("arst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, rand_ent(1'b0), 1'b1, 2'b00); step();
    drive(1'b0, idle, 1'b1, 2'b00); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
